direct_corr_sched: RTL and testbench
====================================

// Module: direct_corr_sched
// PURPOSE
//  Sequences the direct correspondence pipeline for one frame pair over N pose iterations.
//  Per iteration: streams every pixel index into the pipeline and marks frame start/end.
//  Holds the pose stable for the whole pass, waits for the pipeline to drain,
//  then hands off to the pose solver and loads the returned pose for the next pass.
//  Sits between the frame-buffer reader and the solver, above the correspondence datapath.
// PARAMETERS
//  ITER_BW    4   width of iteration count register
//  DRAIN_CYC  16  idle cycles after last pixel; must be >= pipeline latency (12) + 1
// PORTS
//  i_clk           in   1             clock
//  i_rst_n         in   1             async active-low reset
//  i_start         in   1             pulse: begin a new frame pair (ignored unless IDLE)
//  i_abort         in   1             level: return to IDLE at next edge from any state
//  i_init_pose     in   POSE_BW x12   initial pose, sampled on accepted i_start
//  i_pix_ready     in   1             frame-buffer reader accepts current pixel index
//  i_solve_done    in   1             pulse: solver finished, i_solve_pose valid
//  i_solve_pose    in   POSE_BW x12   updated pose from solver
//  r_hsize         in   H_SIZE_BW     frame width, sampled on accepted i_start
//  r_vsize         in   V_SIZE_BW     frame height, sampled on accepted i_start
//  r_iter_num      in   ITER_BW       iteration count, sampled on start; 0 treated as 1
//  o_pix_valid     out  1             pixel index valid (reader fetch + datapath i_valid)
//  o_pix_x         out  H_SIZE_BW     current pixel column
//  o_pix_y         out  V_SIZE_BW     current pixel row
//  o_frame_start   out  1             high with first accepted pixel of a pass
//  o_frame_end     out  1             high with last accepted pixel of a pass
//  o_pose          out  POSE_BW x12   pose driven to datapath; changes only outside STREAM/DRAIN
//  o_solve_req     out  1             one-cycle pulse on entering SOLVE
//  o_iter_idx      out  ITER_BW       current iteration, 0-based
//  o_busy          out  1             high in every state except IDLE
//  o_done          out  1             one-cycle pulse when final iteration's solve completes
// BEHAVIOUR
//  Reset: all outputs 0, o_pose all 0, state IDLE, counters 0.
//  FSM: IDLE -> STREAM on i_start (latch sizes, iter_num, init pose; iter_idx=0).
//   STREAM: o_pix_valid=1; x/y advance only on o_pix_valid&&i_pix_ready; x wraps at
//    hsize-1 to 0 and increments y; last pixel = (hsize-1, vsize-1) accepted -> DRAIN.
//   Index holds while i_pix_ready=0; frame_start/frame_end qualified by ready (held with index).
//   DRAIN: count DRAIN_CYC cycles, o_pix_valid=0 -> SOLVE.
//   SOLVE: o_solve_req pulses first cycle; wait i_solve_done; on done latch i_solve_pose
//    into o_pose; if iter_idx==iter_num-1 -> IDLE with o_done pulse, else iter_idx+1,
//    x=y=0 -> STREAM. Done arriving in first SOLVE cycle is accepted.
//  Latency: first o_pix_valid one cycle after accepted i_start.
//  i_start while busy: ignored. i_solve_done outside SOLVE: ignored.
//  i_abort: wins over all events; clears counters, valid, req; o_pose kept; no o_done.
//  1x1 frame: single pixel carries frame_start and frame_end together.
//  Mid-operation reset: immediate return to reset values; no partial pulse afterward.
//  Counter arithmetic unsigned; sizes of 0 are illegal (not checked).
// STRUCTURE
//  Shared package RgbdVoConfigPk: POSE_BW, H_SIZE_BW, V_SIZE_BW, CORR_PIPE_LAT=12,
//   typedef enum {IDLE, STREAM, DRAIN, SOLVE} corr_sched_state_e.
//  One sub-module: pixel_scan_cnt (x/y raster counter with enable, clear, last flag).
// TESTING
//  4x3 frame, iter_num=2, ready=1 -> 12 valids per pass, start on (0,0), end on (3,2), 2 solve_req, 1 done.
//  Ready toggles every other cycle on 4x3 -> indices never skip/repeat, 12 accepted, end held until accepted.
//  Solver returns pose P1 -> o_pose==P1 from first pixel of pass 2; constant during STREAM/DRAIN.
//  i_abort in DRAIN of iter 0 -> IDLE next cycle, busy=0, no solve_req, no done.
//  iter_num=0, 1x1 frame -> one pixel with start&end both high, one pass, done after solve_done.
//  i_start during STREAM and i_solve_done during STREAM -> no effect; reset mid-STREAM -> all outputs 0.

Source files
------------

// File: rtl/direct_corr_sched_pkg.sv
// Shared configuration for the RGB-D visual odometry correspondence path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package RgbdVoConfigPk;

    localparam int POSE_BW       = 16;
    localparam int POSE_N        = 12;   // 3x4 rigid transform, row-major
    localparam int H_SIZE_BW     = 8;
    localparam int V_SIZE_BW     = 8;
    localparam int CORR_PIPE_LAT = 12;

    typedef logic [POSE_N-1:0][POSE_BW-1:0] pose_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        SOLVE  = 2'd3
    } corr_sched_state_e;

endpackage

// File: rtl/direct_corr_sched_scan_cnt.sv
// Raster x/y pixel counter: x wraps at hsize-1 into y, full wrap at the last pixel.
// Latency: index advances one cycle after an enabled cycle; first/last flags are combinational.
// Backpressure: index holds whenever i_en is low; i_clr has priority over i_en.
// Ports: i_clk/i_rst_n clock and async reset, i_clr/i_en control, i_hsize/i_vsize
//        frame size, o_x/o_y current index, o_first/o_last position flags.
module pixel_scan_cnt
    import RgbdVoConfigPk::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [H_SIZE_BW-1:0] i_hsize,
    input  logic [V_SIZE_BW-1:0] i_vsize,
    output logic [H_SIZE_BW-1:0] o_x,
    output logic [V_SIZE_BW-1:0] o_y,
    output logic                 o_first,
    output logic                 o_last
);

    logic [H_SIZE_BW-1:0] x_q, x_d;
    logic [V_SIZE_BW-1:0] y_q, y_d;
    logic                 x_end;

    assign x_end   = (x_q == i_hsize - H_SIZE_BW'(1));
    assign o_first = (x_q == '0) && (y_q == '0);
    assign o_last  = x_end && (y_q == i_vsize - V_SIZE_BW'(1));
    assign o_x     = x_q;
    assign o_y     = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (i_clr) begin
            x_d = '0;
            y_d = '0;
        end else if (i_en) begin
            if (o_last) begin
                // wrap to origin so the next pass starts clean without an extra clear
                x_d = '0;
                y_d = '0;
            end else if (x_end) begin
                x_d = '0;
                y_d = y_q + V_SIZE_BW'(1);
            end else begin
                x_d = x_q + H_SIZE_BW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/direct_corr_sched.sv
// Sequences N pose iterations of the direct correspondence pass for one frame pair.
// Latency: first pixel index one cycle after accepted i_start; DRAIN_CYC idle cycles before solve.
// Backpressure: pixel index, frame_start/frame_end hold while i_pix_ready is low.
// Ports: i_start/i_abort control, r_* sizes and iteration count, i_init_pose and
//        solver handshake (i_solve_done/i_solve_pose) in; pixel stream (o_pix_*,
//        o_frame_*), o_pose, o_solve_req, o_iter_idx, o_busy, o_done out.
module direct_corr_sched
    import RgbdVoConfigPk::*;
#(
    parameter int ITER_BW   = 4,
    parameter int DRAIN_CYC = CORR_PIPE_LAT + 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  pose_t                i_init_pose,
    input  logic                 i_pix_ready,
    input  logic                 i_solve_done,
    input  pose_t                i_solve_pose,
    input  logic [H_SIZE_BW-1:0] r_hsize,
    input  logic [V_SIZE_BW-1:0] r_vsize,
    input  logic [ITER_BW-1:0]   r_iter_num,
    output logic                 o_pix_valid,
    output logic [H_SIZE_BW-1:0] o_pix_x,
    output logic [V_SIZE_BW-1:0] o_pix_y,
    output logic                 o_frame_start,
    output logic                 o_frame_end,
    output pose_t                o_pose,
    output logic                 o_solve_req,
    output logic [ITER_BW-1:0]   o_iter_idx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int DRN_BW = $clog2(DRAIN_CYC + 1);

    corr_sched_state_e    state_q;
    logic [H_SIZE_BW-1:0] hsize_q;
    logic [V_SIZE_BW-1:0] vsize_q;
    logic [ITER_BW-1:0]   iter_num_q;
    logic [ITER_BW-1:0]   iter_idx_q;
    logic [DRN_BW-1:0]    drain_q;
    pose_t                pose_q;
    logic                 pix_valid_q;
    logic                 solve_req_q;
    logic                 done_q;

    logic scan_clr, scan_en, scan_first, scan_last, last_acc;

    // counter sits at origin whenever idle, so no separate clear is needed on start
    assign scan_clr = i_abort || (state_q == IDLE);
    assign scan_en  = pix_valid_q && i_pix_ready;
    assign last_acc = scan_en && scan_last;

    pixel_scan_cnt u_scan (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (scan_clr),
        .i_en    (scan_en),
        .i_hsize (hsize_q),
        .i_vsize (vsize_q),
        .o_x     (o_pix_x),
        .o_y     (o_pix_y),
        .o_first (scan_first),
        .o_last  (scan_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            hsize_q     <= '0;
            vsize_q     <= '0;
            iter_num_q  <= '0;
            iter_idx_q  <= '0;
            drain_q     <= '0;
            pose_q      <= '0;
            pix_valid_q <= 1'b0;
            solve_req_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            solve_req_q <= 1'b0;
            done_q      <= 1'b0;
            if (i_abort) begin
                // pose intentionally kept so a restart can observe the last estimate
                state_q     <= IDLE;
                pix_valid_q <= 1'b0;
                iter_idx_q  <= '0;
                drain_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            hsize_q     <= r_hsize;
                            vsize_q     <= r_vsize;
                            iter_num_q  <= (r_iter_num == '0) ? ITER_BW'(1) : r_iter_num;
                            iter_idx_q  <= '0;
                            pose_q      <= i_init_pose;
                            pix_valid_q <= 1'b1;
                            state_q     <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (last_acc) begin
                            pix_valid_q <= 1'b0;
                            drain_q     <= '0;
                            state_q     <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (drain_q == DRN_BW'(DRAIN_CYC - 1)) begin
                            drain_q     <= '0;
                            solve_req_q <= 1'b1;
                            state_q     <= SOLVE;
                        end else begin
                            drain_q <= drain_q + DRN_BW'(1);
                        end
                    end
                    SOLVE: begin
                        if (i_solve_done) begin
                            pose_q <= i_solve_pose;
                            if (iter_idx_q == iter_num_q - ITER_BW'(1)) begin
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                iter_idx_q  <= iter_idx_q + ITER_BW'(1);
                                pix_valid_q <= 1'b1;
                                state_q     <= STREAM;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_pix_valid   = pix_valid_q;
    assign o_frame_start = pix_valid_q && scan_first;
    assign o_frame_end   = pix_valid_q && scan_last;
    assign o_pose        = pose_q;
    assign o_solve_req   = solve_req_q;
    assign o_iter_idx    = iter_idx_q;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;

endmodule

// File: tb/tb_direct_corr_sched.sv
module tb_direct_corr_sched;
    import RgbdVoConfigPk::*;

    logic                 i_clk;
    logic                 i_rst_n;
    logic                 i_start;
    logic                 i_abort;
    pose_t                i_init_pose;
    logic                 i_pix_ready;
    logic                 i_solve_done;
    pose_t                i_solve_pose;
    logic [H_SIZE_BW-1:0] r_hsize;
    logic [V_SIZE_BW-1:0] r_vsize;
    logic [3:0]           r_iter_num;
    logic                 o_pix_valid;
    logic [H_SIZE_BW-1:0] o_pix_x;
    logic [V_SIZE_BW-1:0] o_pix_y;
    logic                 o_frame_start;
    logic                 o_frame_end;
    pose_t                o_pose;
    logic                 o_solve_req;
    logic [3:0]           o_iter_idx;
    logic                 o_busy;
    logic                 o_done;

    direct_corr_sched dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_init_pose   (i_init_pose),
        .i_pix_ready   (i_pix_ready),
        .i_solve_done  (i_solve_done),
        .i_solve_pose  (i_solve_pose),
        .r_hsize       (r_hsize),
        .r_vsize       (r_vsize),
        .r_iter_num    (r_iter_num),
        .o_pix_valid   (o_pix_valid),
        .o_pix_x       (o_pix_x),
        .o_pix_y       (o_pix_y),
        .o_frame_start (o_frame_start),
        .o_frame_end   (o_frame_end),
        .o_pose        (o_pose),
        .o_solve_req   (o_solve_req),
        .o_iter_idx    (o_iter_idx),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int    n_vec = 0;
    int    n_err = 0;
    pose_t pose_tbl [0:3];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full frame-pair run with a bench-side raster model and a simple solver.
    task automatic run_pair(input int h, input int v, input int itn, input bit toggle_rdy,
                            input int slv_dly, input bit inject);
        int passes;
        int ex, ey, pass, acc, nreq, ndone, cnt, cyc;
        bit pend, fin;
        passes = (itn == 0) ? 1 : itn;
        ex = 0; ey = 0; pass = 0; acc = 0; nreq = 0; ndone = 0; cnt = 0; cyc = 0;
        pend = 1'b0; fin = 1'b0;
        @(negedge i_clk);
        r_hsize     = H_SIZE_BW'(h);
        r_vsize     = V_SIZE_BW'(v);
        r_iter_num  = 4'(itn);
        i_init_pose = pose_tbl[0];
        i_start     = 1'b1;
        while (!fin && cyc < 3000) begin
            @(negedge i_clk);
            i_start      = 1'b0;
            i_solve_done = 1'b0;
            i_pix_ready  = toggle_rdy ? (cyc % 2 == 1) : 1'b1;
            if (cyc == 0) begin
                chk("first_valid", o_pix_valid, 1'b1);
                chk("busy_on", o_busy, 1'b1);
            end
            if (o_busy) chk("pose_hold", o_pose, pose_tbl[pass]);
            if (o_pix_valid) begin
                chk("pix_x", o_pix_x, ex);
                chk("pix_y", o_pix_y, ey);
                chk("fstart", o_frame_start, (ex == 0 && ey == 0));
                chk("fend", o_frame_end, (ex == h - 1 && ey == v - 1));
                chk("iter_idx", o_iter_idx, pass);
                if (i_pix_ready) begin
                    acc++;
                    if (ex == h - 1) begin
                        ex = 0;
                        ey = (ey == v - 1) ? 0 : ey + 1;
                    end else begin
                        ex++;
                    end
                    if (inject && acc == 2) begin
                        i_start      = 1'b1;
                        i_solve_done = 1'b1;
                        i_solve_pose = pose_tbl[3];
                    end
                end
            end
            if (o_solve_req) begin
                nreq++;
                pend = 1'b1;
                cnt  = slv_dly;
            end
            if (pend) begin
                if (cnt == 0) begin
                    i_solve_done = 1'b1;
                    i_solve_pose = pose_tbl[pass + 1];
                    pend = 1'b0;
                    pass++;
                end else begin
                    cnt--;
                end
            end
            if (o_done) begin
                ndone++;
                fin = 1'b1;
                chk("done_pass", pass, passes);
            end
            cyc++;
        end
        if (!fin) chk("timeout", 1'b0, 1'b1);
        chk("acc_cnt", acc, h * v * passes);
        chk("req_cnt", nreq, passes);
        chk("done_cnt", ndone, 1);
        @(negedge i_clk);
        i_solve_done = 1'b0;
        chk("idle_busy", o_busy, 1'b0);
        chk("done_pulse", o_done, 1'b0);
        chk("pose_final", o_pose, pose_tbl[passes]);
    endtask

    task automatic abort_in_drain();
        int  cyc, ndr, nbad;
        bit  seen;
        cyc = 0; ndr = 0; nbad = 0; seen = 1'b0;
        @(negedge i_clk);
        r_hsize = 8'd4; r_vsize = 8'd3; r_iter_num = 4'd2;
        i_init_pose = pose_tbl[0];
        i_pix_ready = 1'b1;
        i_start = 1'b1;
        while (ndr < 2 && cyc < 200) begin
            @(negedge i_clk);
            i_start = 1'b0;
            if (o_pix_valid) seen = 1'b1;
            else if (seen && o_busy) ndr++;
            cyc++;
        end
        if (ndr < 2) chk("abort_timeout", 1'b0, 1'b1);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_valid", o_pix_valid, 1'b0);
        chk("abort_iter", o_iter_idx, 0);
        chk("abort_pose", o_pose, pose_tbl[0]);
        i_solve_done = 1'b1;
        i_solve_pose = pose_tbl[3];
        for (int k = 0; k < 30; k++) begin
            @(negedge i_clk);
            i_solve_done = 1'b0;
            if (o_solve_req || o_done || o_busy) nbad++;
        end
        chk("abort_quiet", nbad, 0);
        chk("abort_pose2", o_pose, pose_tbl[0]);
    endtask

    task automatic reset_mid_stream();
        int nbad;
        nbad = 0;
        @(negedge i_clk);
        r_hsize = 8'd4; r_vsize = 8'd3; r_iter_num = 4'd2;
        i_init_pose = pose_tbl[1];
        i_pix_ready = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_pre_valid", o_pix_valid, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_valid", o_pix_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_xy", {o_pix_x, o_pix_y}, 16'h0);
        chk("rst_flags", {o_frame_start, o_frame_end, o_solve_req, o_done}, 4'h0);
        chk("rst_pose", o_pose, 192'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_pix_valid || o_busy || o_solve_req || o_done) nbad++;
        end
        chk("rst_quiet", nbad, 0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < POSE_N; j++)
                pose_tbl[k][j] = POSE_BW'(16'h1000 * (k + 1) + 16'h0011 * j + 3);
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_init_pose  = '0;
        i_pix_ready  = 1'b0;
        i_solve_done = 1'b0;
        i_solve_pose = '0;
        r_hsize      = '0;
        r_vsize      = '0;
        r_iter_num   = '0;
        repeat (3) @(negedge i_clk);
        chk("reset_valid", o_pix_valid, 1'b0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_pose", o_pose, 192'h0);
        chk("reset_misc", {o_solve_req, o_done, o_iter_idx, o_frame_start, o_frame_end}, 8'h0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_pair(4, 3, 2, 1'b0, 3, 1'b0);   // basic 4x3, two iterations
        run_pair(4, 3, 2, 1'b1, 5, 1'b1);   // ready toggling, stray start/solve_done
        run_pair(1, 1, 0, 1'b0, 0, 1'b0);   // 1x1, iter_num 0, done in first SOLVE cycle
        abort_in_drain();
        reset_mid_stream();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
